mem_write_checker: RTL and testbench

//   Synthesizable, parametrised successor to the single-address pass/fail bench check for the multi-cycle MIPS CPU.

---
 rtl/mem_write_checker_pkg.sv | 21 ++
 rtl/mem_write_checker_entry.sv | 20 ++
 rtl/mem_write_checker.sv | 162 ++++++++++++++++
 tb/tb_mem_write_checker.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_checker_pkg.sv
// Shared types, constants and helpers for the data-memory write checker.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} chk_state_t;

    localparam int MAX_CHECKS = 16;
    localparam int IDX_W_MAX  = 5;

    localparam logic [IDX_W_MAX-1:0] FAIL_IDX_NONE = '1;

    // Index of the lowest set bit; FAIL_IDX_NONE when nothing is set.
    function automatic logic [IDX_W_MAX-1:0] lowest_set(input logic [MAX_CHECKS-1:0] vec);
        logic [IDX_W_MAX-1:0] idx;
        idx = FAIL_IDX_NONE;
        for (int i = MAX_CHECKS - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W_MAX'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_write_checker_entry.sv
// One expectation slot: flags a write aimed at this entry and whether its data agrees.
module mwc_entry_match #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0] exp_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              armed,
    output logic              addr_hit,
    output logic              data_ok
);

    // armed = entry enabled for this run and not yet satisfied
    assign addr_hit = memwrite && armed && (dataadr == exp_addr);
    assign data_ok  = (writedata == exp_data);

endmodule

// File: rtl/mem_write_checker.sv
// Watches the CPU data-memory write bus for a list of expected (address, data) writes.
// Define CHECK_ORDER_EN to require enabled entries to be hit in ascending index order.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_CHECKS = 4,
    parameter int CYC_W      = 32,
    parameter int TIMEOUT    = 1000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           memwrite,
    input  logic [ADDR_W-1:0]              dataadr,
    input  logic [DATA_W-1:0]              writedata,
    input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
    input  logic [NUM_CHECKS-1:0]          exp_en,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic [$clog2(NUM_CHECKS):0]    fail_idx,
    output logic [DATA_W-1:0]              fail_data,
    output logic [NUM_CHECKS-1:0]          hit_mask,
    output logic [CYC_W-1:0]               cycle_cnt
);

    localparam int IDX_W = $clog2(NUM_CHECKS) + 1;
    localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(FAIL_IDX_NONE);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    chk_state_t state_q, state_d;

    logic [NUM_CHECKS-1:0] en_q, en_d;
    logic [NUM_CHECKS-1:0] hit_q, hit_d;
    logic [CYC_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  to_q, to_d;

    logic [NUM_CHECKS-1:0] addr_hit;
    logic [NUM_CHECKS-1:0] data_ok;
    logic [NUM_CHECKS-1:0] win_onehot;
    logic [NUM_CHECKS-1:0] hit_new;
    logic [IDX_W-1:0]      win_idx;
    logic                  any_hit;
    logic                  win_ok;
    logic                  order_err;
    logic                  mismatch;
    logic                  complete;
    logic                  timeout_now;

    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_entry
        mwc_entry_match #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_match (
            .memwrite  (memwrite),
            .dataadr   (dataadr),
            .writedata (writedata),
            .exp_addr  (exp_addr[i*ADDR_W +: ADDR_W]),
            .exp_data  (exp_data[i*DATA_W +: DATA_W]),
            .armed     (en_q[i] & ~hit_q[i]),
            .addr_hit  (addr_hit[i]),
            .data_ok   (data_ok[i])
        );
    end

    // When several entries share an address, the lowest pending index takes the write.
    assign any_hit    = |addr_hit;
    assign win_onehot = addr_hit & (~addr_hit + NUM_CHECKS'(1));
    assign win_ok     = |(win_onehot & data_ok);
    assign win_idx    = IDX_W'(lowest_set(MAX_CHECKS'(addr_hit)));

`ifdef CHECK_ORDER_EN
    logic [NUM_CHECKS-1:0] pending;
    logic [NUM_CHECKS-1:0] next_onehot;

    // The winner is always pending, so any difference means it jumped ahead.
    assign pending     = en_q & ~hit_q;
    assign next_onehot = pending & (~pending + NUM_CHECKS'(1));
    assign order_err   = any_hit && (win_onehot != next_onehot);
`else
    assign order_err   = 1'b0;
`endif

    assign mismatch    = any_hit && (!win_ok || order_err);
    assign hit_new     = hit_q | (mismatch ? '0 : win_onehot);
    assign complete    = ((hit_new & en_q) == en_q);
    assign timeout_now = (TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= IDX_NONE;
            data_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            to_q    <= to_d;
        end
    end

    // Mismatch beats both completion and timeout; completion beats timeout.
    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        to_d    = to_q;

        if (start) begin
            state_d = S_RUN;
            en_d    = exp_en;
            hit_d   = '0;
            cnt_d   = '0;
            idx_d   = IDX_NONE;
            data_d  = '0;
            to_d    = 1'b0;
        end else if (state_q == S_RUN) begin
            if (cnt_q != '1) cnt_d = cnt_q + CYC_W'(1);
            if (mismatch) begin
                state_d = S_FAIL;
                idx_d   = win_idx;
                data_d  = writedata;
            end else begin
                hit_d = hit_new;
                if (complete) begin
                    state_d = S_PASS;
                end else if (timeout_now) begin
                    state_d = S_FAIL;
                    to_d    = 1'b1;
                end
            end
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_PASS) || (state_q == S_FAIL);
    assign pass      = (state_q == S_PASS);
    assign fail      = (state_q == S_FAIL);
    assign timeout   = to_q;
    assign fail_idx  = idx_q;
    assign fail_data = data_q;
    assign hit_mask  = hit_q;
    assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed scoreboard bench for mem_write_checker (4 entries, TIMEOUT=20) plus a
// narrow-counter, no-timeout instance sharing the same stimulus.
module tb_mem_write_checker;

    localparam int NC = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             memwrite;
    logic [AW-1:0]    dataadr;
    logic [DW-1:0]    writedata;
    logic [NC*AW-1:0] exp_addr;
    logic [NC*DW-1:0] exp_data;
    logic [NC-1:0]    exp_en;

    logic          busy, done, pass, fail, timeout;
    logic [2:0]    fail_idx;
    logic [DW-1:0] fail_data;
    logic [NC-1:0] hit_mask;
    logic [31:0]   cycle_cnt;

    logic          busy2, done2, pass2, fail2, timeout2;
    logic [2:0]    fail_idx2;
    logic [DW-1:0] fail_data2;
    logic [NC-1:0] hit_mask2;
    logic [3:0]    cycle_cnt2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic        fail;
        logic        tout;
        logic [2:0]  idx;
        logic [31:0] data;
        logic [3:0]  hit;
        logic [31:0] cnt;
    } exp_t;

    exp_t  expQ[$];
    string tagQ[$];

    always #5 clk = ~clk;

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .CYC_W(32), .TIMEOUT(20)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_en(exp_en), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout), .fail_idx(fail_idx),
        .fail_data(fail_data), .hit_mask(hit_mask), .cycle_cnt(cycle_cnt)
    );

    mem_write_checker #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_CHECKS(NC), .CYC_W(4), .TIMEOUT(0)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .exp_addr(exp_addr),
        .exp_data(exp_data), .exp_en(exp_en), .busy(busy2), .done(done2),
        .pass(pass2), .fail(fail2), .timeout(timeout2), .fail_idx(fail_idx2),
        .fail_data(fail_data2), .hit_mask(hit_mask2), .cycle_cnt(cycle_cnt2)
    );

    function automatic exp_t expIdle();
        exp_t e;
        e = '0;
        e.idx = 3'b111;
        return e;
    endfunction

    function automatic exp_t expRun(input logic [3:0] hit, input logic [31:0] cnt);
        exp_t e;
        e = expIdle();
        e.busy = 1'b1;
        e.hit  = hit;
        e.cnt  = cnt;
        return e;
    endfunction

    function automatic exp_t expPass(input logic [3:0] hit, input logic [31:0] cnt);
        exp_t e;
        e = expIdle();
        e.done = 1'b1;
        e.pass = 1'b1;
        e.hit  = hit;
        e.cnt  = cnt;
        return e;
    endfunction

    function automatic exp_t expFail(input logic [2:0] idx, input logic [31:0] data,
                                     input logic [3:0] hit, input logic [31:0] cnt,
                                     input logic tout);
        exp_t e;
        e = expIdle();
        e.done = 1'b1;
        e.fail = 1'b1;
        e.idx  = idx;
        e.data = data;
        e.hit  = hit;
        e.cnt  = cnt;
        e.tout = tout;
        return e;
    endfunction

    task automatic setEntry(input int i, input logic [31:0] a, input logic [31:0] d);
        exp_addr[i*AW +: AW] = a;
        exp_data[i*DW +: DW] = d;
    endtask

    task automatic pushExp(input string tag, input exp_t e);
        expQ.push_back(e);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput();
        exp_t  e;
        string tag;
        logic [4:0] obsFlags, expFlags;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e   = expQ.pop_front();
        tag = tagQ.pop_front();
        obsFlags = {busy, done, pass, fail, timeout};
        expFlags = {e.busy, e.done, e.pass, e.fail, e.tout};
        checks++;
        assert (obsFlags === expFlags) else begin
            failures++;
            $error("[TB] FAIL %s flags(busy,done,pass,fail,timeout) observed=%b expected=%b", tag, obsFlags, expFlags);
        end
        checks++;
        assert (fail_idx === e.idx) else begin
            failures++;
            $error("[TB] FAIL %s fail_idx observed=%0d expected=%0d", tag, fail_idx, e.idx);
        end
        checks++;
        assert (fail_data === e.data) else begin
            failures++;
            $error("[TB] FAIL %s fail_data observed=%h expected=%h", tag, fail_data, e.data);
        end
        checks++;
        assert (hit_mask === e.hit) else begin
            failures++;
            $error("[TB] FAIL %s hit_mask observed=%b expected=%b", tag, hit_mask, e.hit);
        end
        checks++;
        assert (cycle_cnt === e.cnt) else begin
            failures++;
            $error("[TB] FAIL %s cycle_cnt observed=%0d expected=%0d", tag, cycle_cnt, e.cnt);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic st, input logic mw,
                                 input logic [31:0] a, input logic [31:0] d, input exp_t e);
        start     = st;
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        pushExp(tag, e);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        memwrite = 1'b0;
        checkOutput();
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        exp_addr  = '0;
        exp_data  = '0;
        exp_en    = '0;
        repeat (3) @(negedge clk);
        pushExp("reset_state", expIdle());
        checkOutput();
        reset = 1'b1;

        $display("[TB] single entry, correct write");
        setEntry(0, 32'd108, 32'hFE0B);
        exp_en = 4'b0001;
        applyStimulus("t1_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        applyStimulus("t1_write", 0, 1, 108, 32'hFE0B, expPass(4'b0001, 1));
        applyStimulus("t1_sticky", 0, 1, 108, 32'h1234, expPass(4'b0001, 1));

        $display("[TB] single entry, wrong data");
        applyStimulus("t2_restart", 1, 0, 0, 0, expRun(4'b0000, 0));
        applyStimulus("t2_write", 0, 1, 108, 32'hFE0A, expFail(3'd0, 32'hFE0A, 4'b0000, 1, 0));
        applyStimulus("t2_sticky", 0, 0, 0, 0, expFail(3'd0, 32'hFE0A, 4'b0000, 1, 0));

        $display("[TB] unlisted address ignored");
        applyStimulus("t3_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        applyStimulus("t3_unlisted", 0, 1, 200, 32'hDEAD, expRun(4'b0000, 1));
        applyStimulus("t3_write", 0, 1, 108, 32'hFE0B, expPass(4'b0001, 2));

        $display("[TB] timeout");
        applyStimulus("t4_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        for (int i = 1; i <= 19; i++) applyStimulus("t4_run", 0, 0, 0, 0, expRun(4'b0000, i));
        applyStimulus("t4_timeout", 0, 0, 0, 0, expFail(3'b111, 0, 4'b0000, 20, 1));
        applyStimulus("t4_sticky", 0, 0, 0, 0, expFail(3'b111, 0, 4'b0000, 20, 1));
        checks++;
        assert ({busy2, timeout2, cycle_cnt2} === {1'b1, 1'b0, 4'd15}) else begin
            failures++;
            $error("[TB] FAIL t4_saturate_no_timeout observed=%b/%b/%0d expected=1/0/15", busy2, timeout2, cycle_cnt2);
        end

        $display("[TB] mismatch on the timeout edge");
        applyStimulus("t5_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        for (int i = 1; i <= 19; i++) applyStimulus("t5_run", 0, 0, 0, 0, expRun(4'b0000, i));
        applyStimulus("t5_mismatch", 0, 1, 108, 32'hFE0C, expFail(3'd0, 32'hFE0C, 4'b0000, 20, 0));

        $display("[TB] completion on the timeout edge");
        applyStimulus("t6_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        for (int i = 1; i <= 19; i++) applyStimulus("t6_run", 0, 0, 0, 0, expRun(4'b0000, i));
        applyStimulus("t6_complete", 0, 1, 108, 32'hFE0B, expPass(4'b0001, 20));

        $display("[TB] out-of-order hits");
        setEntry(0, 32'd80, 32'd7);
        setEntry(1, 32'd84, 32'd7);
        exp_en = 4'b0011;
        applyStimulus("t7_start", 1, 0, 0, 0, expRun(4'b0000, 0));
`ifdef CHECK_ORDER_EN
        applyStimulus("t7_w84", 0, 1, 84, 7, expFail(3'd1, 32'd7, 4'b0000, 1, 0));
        applyStimulus("t7_w80", 0, 1, 80, 7, expFail(3'd1, 32'd7, 4'b0000, 1, 0));
`else
        applyStimulus("t7_w84", 0, 1, 84, 7, expRun(4'b0010, 1));
        applyStimulus("t7_w80", 0, 1, 80, 7, expPass(4'b0011, 2));
`endif

        $display("[TB] two entries on one address");
        setEntry(0, 32'd108, 32'h11);
        setEntry(1, 32'd108, 32'h22);
        applyStimulus("t8a_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        applyStimulus("t8a_lowest_wins", 0, 1, 108, 32'h22, expFail(3'd0, 32'h22, 4'b0000, 1, 0));
        applyStimulus("t8b_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        applyStimulus("t8b_hit0", 0, 1, 108, 32'h11, expRun(4'b0001, 1));
        applyStimulus("t8b_hit1", 0, 1, 108, 32'h22, expPass(4'b0011, 2));

        $display("[TB] reset mid-run, then empty list");
        applyStimulus("t9_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        applyStimulus("t9_hit0", 0, 1, 108, 32'h11, expRun(4'b0001, 1));
        #2 reset = 1'b0;
        #1;
        pushExp("t9_async_reset", expIdle());
        checkOutput();
        checks++;
        assert ({busy2, cycle_cnt2} === {1'b0, 4'd0}) else begin
            failures++;
            $error("[TB] FAIL t9_async_reset_dut2 observed=%b/%0d expected=0/0", busy2, cycle_cnt2);
        end
        @(negedge clk);
        reset  = 1'b1;
        exp_en = 4'b0000;
        applyStimulus("t9_empty_start", 1, 0, 0, 0, expRun(4'b0000, 0));
        applyStimulus("t9_empty_pass", 0, 0, 0, 0, expPass(4'b0000, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
